stage_decode: RTL and testbench
===============================

# stage_decode

Decode stage of the five-stage pipeline, directly downstream of the fetch stage. It captures `pc_out`/`inst_word` from fetch into an IF/ID register and decodes the instruction. It reads operands from a 16x32 register file and presents a registered ID/EX bundle to execute. It detects load-use hazards and drives `pc_stay` back to fetch; it also squashes wrong-path instructions when execute redirects the PC.

## Interface
- `DBITS`, 32, datapath and instruction width
- `REGS`, 16, register count (index width `RBITS` = 4)
- `clk` in 1: pipeline clock, rising edge
- `reset` in 1: asynchronous, active-high
- `if_pc` in DBITS: fetch `pc_out`
- `if_inst` in DBITS: fetch `inst_word`
- `flush` in 1: execute redirect; same signal as fetch `sel_pc`
- `wb_en` in 1: writeback enable
- `wb_rd` in RBITS: writeback register index
- `wb_data` in DBITS: writeback data
- `pc_stay` out 1: stall request to fetch, combinational
- `id_valid` out 1: ID/EX bundle holds a real instruction
- `id_pc` out DBITS: PC of the instruction
- `id_op` out 4: primary opcode
- `id_fn` out 4: function field
- `id_rd` out RBITS: destination register
- `id_rs1_val` out DBITS: source operand 1
- `id_rs2_val` out DBITS: source operand 2
- `id_imm` out DBITS: sign-extended immediate
- `id_wr_reg` out 1: instruction writes `id_rd`
- `id_is_load` out 1: instruction is a load

## Operation
- Instruction fields:
  - `op` = inst[31:28], `fn` = inst[27:24], `rd` = inst[23:20], `rs1` = inst[19:16], `rs2` = inst[15:12]
  - `imm` = sign-extended inst[15:0]
- Opcode classes:
  - LOAD = 4'h9
  - STORE = 4'h5
  - BRANCH = 4'h2
  - All others are register-writing.
- `id_wr_reg` = valid && op∉{STORE, BRANCH}.
- The sentinel `32'hdead` decodes as a bubble: `id_valid`=0, `id_wr_reg`=0.
- IF/ID register fields: `ifid_valid`, `ifid_pc`, `ifid_inst`.
- Load-use hazard, `stall`, is asserted when all of the following hold:
  - `id_valid && id_is_load && ifid_valid`
  - `id_rd` == `rs1`, or `id_rd` == `rs2` and op∈{ALU-R 4'h0, STORE, BRANCH}
- `pc_stay` = `stall && !flush`.
- Register file has two read ports and one write port. Register 0 is an ordinary register (no hardwired zero).

## Timing
- Reset, asynchronous: all IF/ID and ID/EX fields clear to 0, including every `id_*` output. Register file contents are not reset.
- The IF/ID register takes `ifid_valid`=1 on the first edge after reset deasserts.
- Latency: an instruction present at `if_inst` appears on `id_*` two rising edges later, with no stall.
- Edge priority at each rising edge (highest first):
  1. `flush`=1: `ifid_valid`←0 and `id_valid`←0. Flush overrides stall.
  2. `stall`=1: IF/ID holds; ID/EX loads a bubble (`id_valid`=0, `id_wr_reg`=0, `id_is_load`=0).
  3. Otherwise: IF/ID ← fetch; ID/EX ← decode(IF/ID).
- A stall lasts exactly one cycle per load-use pair, because the bubble clears `id_is_load`.
- Register file writes on the rising edge when `wb_en`=1.
- `reset` asserted mid-stall drops `pc_stay` to 0 asynchronously.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: if `wb_en` and `wb_rd` matches a read index in the same cycle, that read returns `wb_data` (write-before-read).
- Undefined: same-cycle reads return the old register value. The writeback stage must then provide forwarding.

## Structure
- Shared package `processor_pkg` holds:
  - `DBITS`, `RBITS`, `REGS`
  - Opcode constants `OP_ALUR`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`
  - `INST_HALT` = 32'hdead
  - Field bit-position constants
- One sub-module, `reg_file`: 2R1W, parameterised by `DBITS`/`REGS`; contains the bypass compiled under the macro.

## Test plan
- Reset with `if_inst`=32'h0123_4000, then release: cycle 0 `id_valid`=0. Two edges later, `id_valid`=1, `id_rd`=2, `id_op`=0.
- Write r3=32'hCAFE via wb, then decode rs1=3: `id_rs1_val`=32'hCAFE. With the macro, write and read in the same cycle also yields 32'hCAFE; without it, the old value.
- LOAD rd=5 followed by ALU-R rs2=5:
  - `pc_stay`=1 for exactly one cycle and one bubble (`id_valid`=0) is inserted.
  - The ALU instruction then appears with unchanged `id_pc`.
- `flush` and `stall` in the same cycle: `pc_stay`=0. Next edge `ifid_valid`=0 and `id_valid`=0.
- `if_inst`=32'hdead: the bundle has `id_valid`=0 and `id_wr_reg`=0 while the PC keeps presenting it.
- Immediate 16'h8001 → `id_imm`=32'hFFFF_8001; immediate 16'h7FFF → 32'h0000_7FFF.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared pipeline constants, instruction field layout and decode helpers.
package processor_pkg;

  localparam int unsigned DBITS = 32;
  localparam int unsigned REGS  = 16;
  localparam int unsigned RBITS = 4;

  localparam logic [3:0] OP_ALUR   = 4'h0;
  localparam logic [3:0] OP_BRANCH = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h5;
  localparam logic [3:0] OP_LOAD   = 4'h9;

  localparam logic [DBITS-1:0] INST_HALT = 32'h0000_dead;

  // Low bit of each instruction field
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned FN_LSB  = 24;
  localparam int unsigned RD_LSB  = 20;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_LSB = 12;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 16;

  typedef struct packed {
    logic             valid;
    logic [DBITS-1:0] pc;
    logic [3:0]       op;
    logic [3:0]       fn;
    logic [RBITS-1:0] rd;
    logic [DBITS-1:0] rs1_val;
    logic [DBITS-1:0] rs2_val;
    logic [DBITS-1:0] imm;
    logic             wr_reg;
    logic             is_load;
  } id_bundle_t;

  function automatic logic [DBITS-1:0] sext_imm(input logic [DBITS-1:0] inst);
    logic [IMM_W-1:0] imm;
    imm = inst[IMM_LSB +: IMM_W];
    return {{(DBITS - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  // Opcodes whose rs2 field is a real register operand
  function automatic logic reads_rs2(input logic [3:0] op);
    return (op == OP_ALUR) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/reg_file.sv
// 2-read 1-write register file, no reset on contents.
// DECODE_WB_BYPASS_EN: same-cycle write data is forwarded to matching reads.
module reg_file #(
  parameter int unsigned DBITS = 32,
  parameter int unsigned REGS  = 16,
  localparam int unsigned RBITS = $clog2(REGS)
) (
  input  logic             clk_i,
  input  logic [RBITS-1:0] ra1_i,
  input  logic [RBITS-1:0] ra2_i,
  output logic [DBITS-1:0] rd1_o,
  output logic [DBITS-1:0] rd2_o,
  input  logic             we_i,
  input  logic [RBITS-1:0] wa_i,
  input  logic [DBITS-1:0] wd_i
);

  logic [DBITS-1:0] regs_q [REGS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
`ifdef DECODE_WB_BYPASS_EN
    if (we_i && (wa_i == ra1_i)) rd1_o = wd_i;
    if (we_i && (wa_i == ra2_i)) rd2_o = wd_i;
`endif
  end

endmodule

// File: rtl/stage_decode.sv
// Decode stage: IF/ID register, decode, register read, ID/EX register, load-use stall.
// Optional DECODE_WB_BYPASS_EN enables write-before-read in the register file.
module stage_decode
  import processor_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] if_pc,
  input  logic [DBITS-1:0] if_inst,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [RBITS-1:0] wb_rd,
  input  logic [DBITS-1:0] wb_data,
  output logic             pc_stay,
  output logic             id_valid,
  output logic [DBITS-1:0] id_pc,
  output logic [3:0]       id_op,
  output logic [3:0]       id_fn,
  output logic [RBITS-1:0] id_rd,
  output logic [DBITS-1:0] id_rs1_val,
  output logic [DBITS-1:0] id_rs2_val,
  output logic [DBITS-1:0] id_imm,
  output logic             id_wr_reg,
  output logic             id_is_load
);

  logic             ifid_valid_q, ifid_valid_d;
  logic [DBITS-1:0] ifid_pc_q, ifid_pc_d;
  logic [DBITS-1:0] ifid_inst_q, ifid_inst_d;
  id_bundle_t       id_q, id_d, dec;

  logic [3:0]       op;
  logic [RBITS-1:0] rs1, rs2;
  logic [DBITS-1:0] rs1_val, rs2_val;
  logic             stall;

  assign op  = ifid_inst_q[OP_LSB +: 4];
  assign rs1 = ifid_inst_q[RS1_LSB +: RBITS];
  assign rs2 = ifid_inst_q[RS2_LSB +: RBITS];

  reg_file #(
    .DBITS(DBITS),
    .REGS (REGS)
  ) u_reg_file (
    .clk_i(clk),
    .ra1_i(rs1),
    .ra2_i(rs2),
    .rd1_o(rs1_val),
    .rd2_o(rs2_val),
    .we_i (wb_en),
    .wa_i (wb_rd),
    .wd_i (wb_data)
  );

  always_comb begin
    dec         = '0;
    dec.valid   = ifid_valid_q && (ifid_inst_q != INST_HALT);
    dec.pc      = ifid_pc_q;
    dec.op      = op;
    dec.fn      = ifid_inst_q[FN_LSB +: 4];
    dec.rd      = ifid_inst_q[RD_LSB +: RBITS];
    dec.rs1_val = rs1_val;
    dec.rs2_val = rs2_val;
    dec.imm     = sext_imm(ifid_inst_q);
    dec.wr_reg  = dec.valid && (op != OP_STORE) && (op != OP_BRANCH);
    dec.is_load = dec.valid && (op == OP_LOAD);
  end

  // Reset clears id_q asynchronously, which drops the stall with it
  assign stall = id_q.valid && id_q.is_load && ifid_valid_q &&
                 ((id_q.rd == rs1) || ((id_q.rd == rs2) && reads_rs2(op)));
  assign pc_stay = stall && !flush;

  always_comb begin
    ifid_valid_d = 1'b1;
    ifid_pc_d    = if_pc;
    ifid_inst_d  = if_inst;
    id_d         = dec;
    if (flush) begin
      ifid_valid_d = 1'b0;
      id_d.valid   = 1'b0;
      id_d.wr_reg  = 1'b0;
      id_d.is_load = 1'b0;
    end else if (stall) begin
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_inst_d  = ifid_inst_q;
      id_d.valid   = 1'b0;
      id_d.wr_reg  = 1'b0;
      id_d.is_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= '0;
      id_q         <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      id_q         <= id_d;
    end
  end

  assign id_valid   = id_q.valid;
  assign id_pc      = id_q.pc;
  assign id_op      = id_q.op;
  assign id_fn      = id_q.fn;
  assign id_rd      = id_q.rd;
  assign id_rs1_val = id_q.rs1_val;
  assign id_rs2_val = id_q.rs2_val;
  assign id_imm     = id_q.imm;
  assign id_wr_reg  = id_q.wr_reg;
  assign id_is_load = id_q.is_load;

endmodule

// File: tb/tb_stage_decode.sv
// Directed bench for stage_decode: reset, latency, regfile write/bypass, load-use, flush, halt, imm.
module tb_stage_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc, if_inst;
  logic        flush, wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        pc_stay, id_valid, id_wr_reg, id_is_load;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [3:0]  id_op, id_fn, id_rd;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  stage_decode dut (
    .clk       (clk),
    .reset     (reset),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .pc_stay   (pc_stay),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_op     (id_op),
    .id_fn     (id_fn),
    .id_rd     (id_rd),
    .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val),
    .id_imm    (id_imm),
    .id_wr_reg (id_wr_reg),
    .id_is_load(id_is_load)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] exp_same_cycle;
`ifdef DECODE_WB_BYPASS_EN
    exp_same_cycle = 32'h0000_cafe;
`else
    exp_same_cycle = 32'h0000_1003;
`endif
    reset   = 1'b1;
    flush   = 1'b0;
    if_pc   = 32'h100;
    if_inst = 32'h0123_4000;
    wb_en   = 1'b0;
    wb_rd   = '0;
    wb_data = '0;

    // Preload r[i] = 0x1000+i while reset holds the pipeline
    for (int i = 0; i < 16; i++) begin
      wb_en   = 1'b1;
      wb_rd   = 4'(i);
      wb_data = 32'h1000 + 32'(i);
      step();
    end
    wb_en = 1'b0;
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_rd", {28'd0, id_rd}, 32'd0);
    check("rst_imm", id_imm, 32'd0);
    check("rst_wr_reg", {31'd0, id_wr_reg}, 32'd0);
    check("rst_pc_stay", {31'd0, pc_stay}, 32'd0);

    reset = 1'b0;
    step();
    check("lat_e1_valid", {31'd0, id_valid}, 32'd0);
    step();
    check("lat_e2_valid", {31'd0, id_valid}, 32'd1);
    check("lat_e2_rd", {28'd0, id_rd}, 32'd2);
    check("lat_e2_op", {28'd0, id_op}, 32'd0);
    check("lat_e2_fn", {28'd0, id_fn}, 32'd1);
    check("lat_e2_pc", id_pc, 32'h100);
    check("lat_e2_rs1", id_rs1_val, 32'h1003);
    check("lat_e2_rs2", id_rs2_val, 32'h1004);
    check("lat_e2_imm", id_imm, 32'h4000);
    check("lat_e2_wr_reg", {31'd0, id_wr_reg}, 32'd1);
    check("lat_e2_is_load", {31'd0, id_is_load}, 32'd0);

    // Write r3 in the same cycle its read is captured
    wb_en = 1'b1; wb_rd = 4'd3; wb_data = 32'h0000_cafe;
    step();
    wb_en = 1'b0;
    check("wb_same_cycle", id_rs1_val, exp_same_cycle);
    step();
    check("wb_after", id_rs1_val, 32'h0000_cafe);

    // LOAD r5 then ALU-R using rs2=r5
    if_inst = 32'h9051_0000; if_pc = 32'h200;
    step();
    if_inst = 32'h0267_5000; if_pc = 32'h204;
    check("lu_no_stall", {31'd0, pc_stay}, 32'd0);
    step();
    check("lu_load_valid", {31'd0, id_is_load}, 32'd1);
    check("lu_load_pc", id_pc, 32'h200);
    check("lu_stall", {31'd0, pc_stay}, 32'd1);
    step();
    check("lu_bubble", {31'd0, id_valid}, 32'd0);
    check("lu_stall_done", {31'd0, pc_stay}, 32'd0);
    step();
    check("lu_alu_valid", {31'd0, id_valid}, 32'd1);
    check("lu_alu_pc", id_pc, 32'h204);
    check("lu_alu_rd", {28'd0, id_rd}, 32'd6);
    check("lu_alu_rs2", id_rs2_val, 32'h1005);

    // Flush together with a load-use stall
    if_inst = 32'h9070_0000; if_pc = 32'h300;
    step();
    if_inst = 32'h0087_0000; if_pc = 32'h304;
    step();
    check("fl_stall", {31'd0, pc_stay}, 32'd1);
    flush = 1'b1;
    #1;
    check("fl_pc_stay", {31'd0, pc_stay}, 32'd0);
    step();
    flush = 1'b0;
    check("fl_id_valid", {31'd0, id_valid}, 32'd0);
    step();
    check("fl_ifid_cleared", {31'd0, id_valid}, 32'd0);
    step();
    check("fl_resume_valid", {31'd0, id_valid}, 32'd1);
    check("fl_resume_pc", id_pc, 32'h304);

    // Halt sentinel decodes as a bubble
    if_inst = 32'h0000_dead; if_pc = 32'h400;
    step();
    step();
    check("halt_valid", {31'd0, id_valid}, 32'd0);
    check("halt_wr_reg", {31'd0, id_wr_reg}, 32'd0);
    step();
    check("halt_hold_valid", {31'd0, id_valid}, 32'd0);

    // Immediate sign extension
    if_inst = 32'h1010_8001; if_pc = 32'h500;
    step();
    step();
    check("imm_neg", id_imm, 32'hffff_8001);
    check("imm_wr_reg", {31'd0, id_wr_reg}, 32'd1);
    if_inst = 32'h1010_7fff;
    step();
    step();
    check("imm_pos", id_imm, 32'h0000_7fff);

    // Store does not write a register
    if_inst = 32'h5010_0000;
    step();
    step();
    check("st_valid", {31'd0, id_valid}, 32'd1);
    check("st_wr_reg", {31'd0, id_wr_reg}, 32'd0);

    // Reset asserted mid-stall drops pc_stay immediately
    if_inst = 32'h9050_0000; if_pc = 32'h600;
    step();
    if_inst = 32'h0005_0000; if_pc = 32'h604;
    step();
    check("rs_stall", {31'd0, pc_stay}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rs_pc_stay", {31'd0, pc_stay}, 32'd0);
    check("rs_id_valid", {31'd0, id_valid}, 32'd0);
    check("rs_id_pc", id_pc, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
